// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: flag register, condition evaluation, circular
// return-address stack, and a registered redirect / link-write interface to fetch.
module branch_resolve_unit #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid,
    input  logic                         flush,
    input  logic [2:0]                   brOp,
    input  logic                         useRas,
    input  logic [WIDTH-1:0]             pc,
    input  logic [WIDTH-1:0]             branchTarget,
    input  logic [WIDTH-1:0]             op1,
    input  logic                         wrFlag,
    input  logic                         isEq,
    input  logic                         isGt,
    output logic [WIDTH-1:0]             branchPC,
    output logic                         isBranchTaken,
    output logic                         linkWr,
    output logic [WIDTH-1:0]             linkData,
    output logic                         flagE,
    output logic                         flagGt,
    output logic [$clog2(RAS_DEPTH):0]   rasCount,
    output logic                         rasOverflow,
    output logic                         rasUnderflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] OP_B    = 3'b001;
    localparam logic [2:0] OP_BEQ  = 3'b010;
    localparam logic [2:0] OP_BGT  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;

    // Return-address storage; contents are never reset, only ptr/count are.
    logic [WIDTH-1:0] rasMem [RAS_DEPTH];
    logic [PTR_W-1:0] rasPtr;
    logic [PTR_W-1:0] rasTopIdx;
    logic             rasEmpty;
    logic             rasFull;

    logic             effOp;
    logic             condE;
    logic             condGt;
    logic             takeNext;
    logic [WIDTH-1:0] targetNext;
    logic [WIDTH-1:0] linkAddr;
    logic             doPush;
    logic             doPop;
    logic             setUnder;

    // Decode the op, forward fresh compare results, and pick the redirect target.
    always_comb begin
        takeNext   = 1'b0;
        targetNext = branchTarget;
        doPush     = 1'b0;
        doPop      = 1'b0;
        setUnder   = 1'b0;
        rasTopIdx  = rasPtr - PTR_W'(1);
        rasEmpty   = (rasCount == '0);
        rasFull    = (rasCount == CNT_W'(RAS_DEPTH));
        linkAddr   = pc + WIDTH'(4);
        condE      = wrFlag ? isEq : flagE;
        condGt     = wrFlag ? isGt : flagGt;
        effOp      = valid & ~flush & (brOp != 3'b000) & (brOp <= OP_RET);
        if (effOp) begin
            case (brOp)
                OP_B:    takeNext = 1'b1;
                OP_BEQ:  takeNext = condE;
                OP_BGT:  takeNext = condGt;
                OP_CALL: begin
                    takeNext = 1'b1;
                    doPush   = 1'b1;
                end
                OP_RET: begin
                    takeNext = 1'b1;
                    if (useRas && !rasEmpty) begin
                        targetNext = rasMem[rasTopIdx];
                        doPop      = 1'b1;
                    end else begin
                        targetNext = op1;
                        setUnder   = useRas;
                    end
                end
                default: takeNext = 1'b0;
            endcase
        end
    end

    // Registered redirect/link outputs, flags and RAS bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branchPC      <= '0;
            isBranchTaken <= 1'b0;
            linkWr        <= 1'b0;
            linkData      <= '0;
            flagE         <= 1'b0;
            flagGt        <= 1'b0;
            rasPtr        <= '0;
            rasCount      <= '0;
            rasOverflow   <= 1'b0;
            rasUnderflow  <= 1'b0;
        end else begin
            isBranchTaken <= takeNext;
            if (takeNext) begin
                branchPC <= targetNext;
            end
            linkWr <= doPush;
            if (doPush) begin
                linkData <= linkAddr;
            end
            if (wrFlag) begin
                flagE  <= isEq;
                flagGt <= isGt;
            end
            if (doPush) begin
                rasPtr <= rasPtr + PTR_W'(1);
                if (rasFull) begin
                    rasOverflow <= 1'b1;
                end else begin
                    rasCount <= rasCount + CNT_W'(1);
                end
            end else if (doPop) begin
                rasPtr   <= rasTopIdx;
                rasCount <= rasCount - CNT_W'(1);
            end
            if (setUnder) begin
                rasUnderflow <= 1'b1;
            end
        end
    end

    // Stack write on push; a full stack simply overwrites its oldest slot.
    always_ff @(posedge clk) begin
        if (doPush) begin
            rasMem[rasPtr] <= linkAddr;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit (WIDTH=32, RAS_DEPTH=8).
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, flush, useRas, wrFlag, isEq, isGt;
    logic [2:0]  brOp;
    logic [31:0] pc, branchTarget, op1;
    logic [31:0] branchPC, linkData;
    logic        isBranchTaken, linkWr, flagE, flagGt, rasOverflow, rasUnderflow;
    logic [3:0]  rasCount;

    int vecCnt = 0;
    int errCnt = 0;

    typedef struct {
        logic        taken;
        logic [31:0] bpc;
        logic        lwr;
        logic [31:0] ldata;
        logic        fe;
        logic        fg;
        logic [3:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t expQ[$];

    // reference model state
    logic [31:0] mRas [8];
    int          mPtr, mCnt;
    logic        mFe, mFg, mOvf, mUnf;
    logic [31:0] mBpc, mLdata;

    always #5 clk = ~clk;

    branch_resolve_unit #(.WIDTH(32), .RAS_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .valid(valid), .flush(flush), .brOp(brOp),
        .useRas(useRas), .pc(pc), .branchTarget(branchTarget), .op1(op1),
        .wrFlag(wrFlag), .isEq(isEq), .isGt(isGt),
        .branchPC(branchPC), .isBranchTaken(isBranchTaken), .linkWr(linkWr),
        .linkData(linkData), .flagE(flagE), .flagGt(flagGt), .rasCount(rasCount),
        .rasOverflow(rasOverflow), .rasUnderflow(rasUnderflow)
    );

    task automatic chkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mPtr = 0; mCnt = 0; mFe = 0; mFg = 0; mOvf = 0; mUnf = 0;
        mBpc = '0; mLdata = '0;
    endtask

    task automatic idleInputs();
        valid = 0; flush = 0; brOp = 3'b000; useRas = 0; pc = '0;
        branchTarget = '0; op1 = '0; wrFlag = 0; isEq = 0; isGt = 0;
    endtask

    // drive one cycle of stimulus, predict, then compare after the edge
    task automatic doOp(input logic v, input logic fl, input logic [2:0] op, input logic ur,
                        input logic [31:0] p, input logic [31:0] tgt, input logic [31:0] o1,
                        input logic wf, input logic eq, input logic gt);
        exp_t e;
        exp_t g;
        logic eff, ce, cg, tk;
        @(negedge clk);
        valid = v; flush = fl; brOp = op; useRas = ur; pc = p;
        branchTarget = tgt; op1 = o1; wrFlag = wf; isEq = eq; isGt = gt;
        eff = v && !fl && (op >= 3'd1) && (op <= 3'd5);
        ce  = wf ? eq : mFe;
        cg  = wf ? gt : mFg;
        tk  = 1'b0;
        e.lwr = 1'b0;
        if (eff) begin
            case (op)
                3'd1: begin tk = 1; mBpc = tgt; end
                3'd2: if (ce) begin tk = 1; mBpc = tgt; end
                3'd3: if (cg) begin tk = 1; mBpc = tgt; end
                3'd4: begin
                    tk = 1; mBpc = tgt; e.lwr = 1; mLdata = p + 32'd4;
                    mRas[mPtr] = p + 32'd4;
                    mPtr = (mPtr + 1) % 8;
                    if (mCnt == 8) mOvf = 1; else mCnt++;
                end
                default: begin
                    tk = 1;
                    if (ur && mCnt > 0) begin
                        mPtr = (mPtr + 7) % 8;
                        mBpc = mRas[mPtr];
                        mCnt--;
                    end else begin
                        mBpc = o1;
                        if (ur) mUnf = 1;
                    end
                end
            endcase
        end
        if (wf) begin mFe = eq; mFg = gt; end
        e.taken = tk; e.bpc = mBpc; e.ldata = mLdata; e.fe = mFe; e.fg = mFg;
        e.cnt = 4'(mCnt); e.ovf = mOvf; e.unf = mUnf;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        g = expQ.pop_front();
        chkVal("isBranchTaken", 32'(isBranchTaken), 32'(g.taken));
        chkVal("branchPC", branchPC, g.bpc);
        chkVal("linkWr", 32'(linkWr), 32'(g.lwr));
        chkVal("linkData", linkData, g.ldata);
        chkVal("flagE", 32'(flagE), 32'(g.fe));
        chkVal("flagGt", 32'(flagGt), 32'(g.fg));
        chkVal("rasCount", 32'(rasCount), 32'(g.cnt));
        chkVal("rasOverflow", 32'(rasOverflow), 32'(g.ovf));
        chkVal("rasUnderflow", 32'(rasUnderflow), 32'(g.unf));
    endtask

    task automatic checkCleared(input string tag);
        chkVal({tag, ".isBranchTaken"}, 32'(isBranchTaken), 32'd0);
        chkVal({tag, ".branchPC"}, branchPC, 32'd0);
        chkVal({tag, ".linkWr"}, 32'(linkWr), 32'd0);
        chkVal({tag, ".linkData"}, linkData, 32'd0);
        chkVal({tag, ".flags"}, {30'd0, flagE, flagGt}, 32'd0);
        chkVal({tag, ".rasCount"}, 32'(rasCount), 32'd0);
        chkVal({tag, ".sticky"}, {30'd0, rasOverflow, rasUnderflow}, 32'd0);
    endtask

    initial begin
        idleInputs();
        modelReset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkCleared("reset");
        @(negedge clk);
        rst = 1'b0;

        // unconditional branch, then idle: pulse drops, branchPC holds
        doOp(1, 0, 3'd1, 0, 32'h0, 32'h40, 32'h0, 0, 0, 0);
        doOp(0, 0, 3'd0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);

        // BEQ with forwarded compare result
        doOp(1, 0, 3'd2, 0, 32'h0, 32'h20, 32'h0, 1, 1, 0);
        // BGT using stored GT=0, then forwarded GT=1
        doOp(1, 0, 3'd3, 0, 32'h0, 32'h60, 32'h0, 0, 0, 0);
        doOp(1, 0, 3'd3, 0, 32'h0, 32'h64, 32'h0, 1, 0, 1);
        // BEQ using stored E=0 (written last cycle)
        doOp(1, 0, 3'd2, 0, 32'h0, 32'h68, 32'h0, 0, 0, 0);

        // CALL then RET through the stack
        doOp(1, 0, 3'd4, 0, 32'h10, 32'h80, 32'h0, 0, 0, 0);
        doOp(1, 0, 3'd5, 1, 32'h80, 32'h0, 32'hdead, 0, 0, 0);

        // overflow: 9 calls, then 8 returns newest-first
        for (int i = 0; i < 9; i++)
            doOp(1, 0, 3'd4, 0, 32'(i * 4), 32'h100, 32'h0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            doOp(1, 0, 3'd5, 1, 32'h100, 32'h0, 32'h0, 0, 0, 0);

        // underflow falls back to op1
        doOp(1, 0, 3'd5, 1, 32'h0, 32'h0, 32'h1234, 0, 0, 0);
        // flushed CALL: no change, but flags still load
        doOp(1, 1, 3'd4, 0, 32'h30, 32'h90, 32'h0, 1, 1, 1);
        // legacy RET and reserved ops
        doOp(1, 0, 3'd5, 0, 32'h0, 32'h0, 32'h55, 0, 0, 0);
        doOp(1, 0, 3'd6, 1, 32'h0, 32'h70, 32'h77, 0, 0, 0);
        doOp(1, 0, 3'd7, 1, 32'h0, 32'h70, 32'h77, 0, 0, 0);
        // CALL near 2^32 wraps link address
        doOp(1, 0, 3'd4, 0, 32'hFFFF_FFFE, 32'h200, 32'h0, 0, 0, 0);
        doOp(1, 0, 3'd5, 1, 32'h0, 32'h0, 32'h0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 300; i++)
            doOp(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                 $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                 1'($urandom), 1'($urandom), 1'($urandom));

        // reset while a CALL is in flight
        @(negedge clk);
        valid = 1; flush = 0; brOp = 3'd4; pc = 32'h10; branchTarget = 32'h80;
        @(posedge clk);
        #1;
        chkVal("inflight.linkWr", 32'(linkWr), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkCleared("midrst");
        @(negedge clk);
        idleInputs();
        rst = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        checkCleared("postrst");
        doOp(1, 0, 3'd5, 1, 32'h0, 32'h0, 32'h99, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
